counter_timer_n: RTL and testbench

Parametrised N-channel down-counting timer/PWM block; successor to the fixed three-channel Counter_x in the MIO peripheral set.
- Each channel counts edges of its own tick source, typically a clkdiv tap.
- Modes per channel: one-shot, periodic auto-reload, or PWM.
- Programmed through a simple word-addressed register port driven by MIO_BUS.
- Provides per-channel outputs and one combined, maskable interrupt to the CPU INT input.

---
 rtl/counter_timer_n_pkg.sv | 28 ++
 rtl/counter_timer_n_channel.sv | 96 +++++++++
 rtl/counter_timer_n.sv | 75 +++++++
 tb/tb_counter_timer_n.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_timer_n_pkg.sv
// Shared register map, mode encodings and CTRL field positions for the
// N-channel counter/timer block.
package counter_timer_pkg;

  localparam int REGS_PER_CH = 4;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_LOAD  = 2'd1;
  localparam logic [1:0] REG_CMP   = 2'd2;
  localparam logic [1:0] REG_VALUE = 2'd3;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_PWM      = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int CTRL_W        = 4;

  function automatic mode_e ctrl_mode(input logic [CTRL_W-1:0] ctrl);
    return mode_e'(ctrl[CTRL_MODE_LSB +: 2]);
  endfunction

endpackage

// File: rtl/counter_timer_n_channel.sv
// One timer channel: tick synchroniser, CTRL/LOAD/CMP/VALUE registers,
// its STATUS bit and its output (expiry pulse or PWM level).
module timer_channel
  import counter_timer_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_in,
  input  logic              ctrl_we,
  input  logic              load_we,
  input  logic              cmp_we,
  input  logic              status_clr,
  input  logic [CW-1:0]     wdata,
  output logic [CTRL_W-1:0] ctrl,
  output logic [CW-1:0]     load,
  output logic [CW-1:0]     cmp,
  output logic [CW-1:0]     value,
  output logic              status,
  output logic              ch_out
);

  logic sync1_reg, sync2_reg, prev_reg, tick_reg;
  logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
  logic [CW-1:0] load_reg, load_next, cmp_reg, cmp_next, value_reg, value_next;
  logic status_reg, status_next, ch_out_reg, ch_out_next, expire;
  mode_e mode_cur;

  // Edge pulse is registered so VALUE moves on the 4th clk edge after tick_in rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      sync1_reg <= tick_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      tick_reg  <= sync2_reg & ~prev_reg;
    end
  end

  assign mode_cur = ctrl_mode(ctrl_reg);

  always_comb begin
    ctrl_next  = ctrl_reg;
    load_next  = load_we ? wdata : load_reg;
    cmp_next   = cmp_we ? wdata : cmp_reg;
    value_next = value_reg;
    expire     = 1'b0;
    if (ctrl_we) ctrl_next = wdata[CTRL_W-1:0];
    // Enabling loads VALUE and swallows any tick arriving in the same cycle.
    if (ctrl_we && wdata[CTRL_EN] && !ctrl_reg[CTRL_EN]) begin
      value_next = load_reg;
    end else if (ctrl_reg[CTRL_EN] && tick_reg) begin
      if (value_reg != '0) begin
        value_next = value_reg - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        expire = 1'b1;
        if (mode_cur == MODE_PERIODIC || mode_cur == MODE_PWM) value_next = load_reg;
        else ctrl_next[CTRL_EN] = 1'b0;
      end
    end
    status_next = expire | (status_reg & ~status_clr);
    if (ctrl_mode(ctrl_next) == MODE_PWM) ch_out_next = ctrl_next[CTRL_EN] & (value_next < cmp_next);
    else ch_out_next = expire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg   <= '0;
      load_reg   <= '0;
      cmp_reg    <= '0;
      value_reg  <= '0;
      status_reg <= 1'b0;
      ch_out_reg <= 1'b0;
    end else begin
      ctrl_reg   <= ctrl_next;
      load_reg   <= load_next;
      cmp_reg    <= cmp_next;
      value_reg  <= value_next;
      status_reg <= status_next;
      ch_out_reg <= ch_out_next;
    end
  end

  assign ctrl   = ctrl_reg;
  assign load   = load_reg;
  assign cmp    = cmp_reg;
  assign value  = value_reg;
  assign status = status_reg;
  assign ch_out = ch_out_reg;

endmodule

// File: rtl/counter_timer_n.sv
// N-channel down-counting timer/PWM: address decode, read mux and the
// combined maskable interrupt around NCH timer_channel instances.
module counter_timer_n
  import counter_timer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 32
) (
  input  logic           clk,
  input  logic           RSTN,
  input  logic [NCH-1:0] tick_in,
  input  logic [7:0]     addr,
  input  logic           we,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata,
  output logic [NCH-1:0] ch_out,
  output logic           irq
);

  localparam logic [7:0] STATUS_ADDR = 8'(REGS_PER_CH * NCH);

  logic [NCH-1:0]        status, irq_en;
  logic [NCH-1:0][31:0]  rd_words;
  logic                  status_wr, irq_reg;
  logic                  unused_wdata;

  assign status_wr    = we && (addr == STATUS_ADDR);
  assign unused_wdata = ^{1'b0, wdata};

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic              hit;
    logic [CTRL_W-1:0] ctrl;
    logic [CW-1:0]     load, cmp, value;

    // Channel window is addr[7:2]; the STATUS word lies just past the last one.
    assign hit = (addr[7:2] == 6'(gi));

    timer_channel #(.CW(CW)) u_ch (
      .clk        (clk),
      .rst_n      (RSTN),
      .tick_in    (tick_in[gi]),
      .ctrl_we    (we && hit && (addr[1:0] == REG_CTRL)),
      .load_we    (we && hit && (addr[1:0] == REG_LOAD)),
      .cmp_we     (we && hit && (addr[1:0] == REG_CMP)),
      .status_clr (status_wr && wdata[gi]),
      .wdata      (wdata[CW-1:0]),
      .ctrl       (ctrl),
      .load       (load),
      .cmp        (cmp),
      .value      (value),
      .status     (status[gi]),
      .ch_out     (ch_out[gi])
    );

    assign irq_en[gi]   = ctrl[CTRL_IRQ_EN];
    assign rd_words[gi] = !hit                      ? 32'd0 :
                          (addr[1:0] == REG_CTRL)   ? 32'(ctrl) :
                          (addr[1:0] == REG_LOAD)   ? 32'(load) :
                          (addr[1:0] == REG_CMP)    ? 32'(cmp) : 32'(value);
  end

  always_comb begin
    rdata = '0;
    if (addr == STATUS_ADDR) rdata = 32'(status);
    for (int i = 0; i < NCH; i++) rdata = rdata | rd_words[i];
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) irq_reg <= 1'b0;
    else       irq_reg <= |(status & irq_en);
  end

  assign irq = irq_reg;

endmodule

// File: tb/tb_counter_timer_n.sv
// Directed bench for counter_timer_n: expected values are queued as stimulus
// is applied and popped when the corresponding DUT output is sampled.
`timescale 1ns/1ps
module tb_counter_timer_n;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           RSTN = 1'b0;
  logic [NCH-1:0] tick_in = '0;
  logic [7:0]     addr = '0;
  logic           we = 1'b0;
  logic [31:0]    wdata = '0;
  logic [31:0]    rdata;
  logic [NCH-1:0] ch_out;
  logic           irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int pulses[NCH];

  always #50 clk = ~clk;

  counter_timer_n #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .RSTN(RSTN), .tick_in(tick_in), .addr(addr), .we(we),
    .wdata(wdata), .rdata(rdata), .ch_out(ch_out), .irq(irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) pulses[i] += int'(ch_out[i]);
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: observed %0h but no expected value queued", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [7:0] a, input logic [31:0] e);
    logic [31:0] d;
    expect_val(e);
    addr = a;
    #1;
    d = rdata;
    check(tag, d);
  endtask

  task automatic check_sig(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_val(e);
    check(tag, obs);
  endtask

  task automatic do_tick(input int c);
    tick_in[c] = 1'b1;
    step(); step();
    tick_in[c] = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    logic [7:0] load_seq [8];
    int cnt;
    load_seq = '{8'd1, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd4};
    for (int i = 0; i < NCH; i++) pulses[i] = 0;

    // Reset state
    step(); step();
    check_rd("rst_ctrl0", 8'd0, 32'd0);
    check_rd("rst_status", 8'd16, 32'd0);
    check_sig("rst_irq", 32'(irq), 32'd0);
    check_sig("rst_chout", 32'(ch_out), 32'd0);
    RSTN = 1'b1;
    step();

    // One-shot on ch0
    wr(8'd1, 32'd3);
    wr(8'd0, 32'd9);
    check_rd("os_value_init", 8'd3, 32'd3);
    tick_in[0] = 1'b1;
    step(); step();
    tick_in[0] = 1'b0;
    step();
    check_rd("os_lat_edge3", 8'd3, 32'd3);
    step();
    check_rd("os_lat_edge4", 8'd3, 32'd2);
    step();
    do_tick(0);
    check_rd("os_value_1", 8'd3, 32'd1);
    do_tick(0);
    check_rd("os_value_0", 8'd3, 32'd0);
    pulses[0] = 0;
    do_tick(0);
    check_rd("os_status", 8'd16, 32'd1);
    check_sig("os_irq", 32'(irq), 32'd1);
    check_rd("os_ctrl_autoclr", 8'd0, 32'd8);
    check_sig("os_pulse", 32'(pulses[0]), 32'd1);
    do_tick(0);
    check_rd("os_after_value", 8'd3, 32'd0);
    check_sig("os_after_pulse", 32'(pulses[0]), 32'd1);
    wr(8'd16, 32'd1);
    step();
    check_rd("os_w1c", 8'd16, 32'd0);
    check_sig("os_irq_clr", 32'(irq), 32'd0);

    // Reset in the middle of a periodic count on ch0
    wr(8'd1, 32'd5);
    wr(8'd0, 32'd11);
    for (int k = 0; k < 7; k++) do_tick(0);
    check_rd("rm_value_pre", 8'd3, 32'd4);
    check_sig("rm_irq_pre", 32'(irq), 32'd1);
    RSTN = 1'b0;
    #1;
    check_rd("rm_value", 8'd3, 32'd0);
    check_rd("rm_status", 8'd16, 32'd0);
    check_rd("rm_ctrl", 8'd0, 32'd0);
    check_sig("rm_irq", 32'(irq), 32'd0);
    check_sig("rm_chout", 32'(ch_out), 32'd0);
    step();
    RSTN = 1'b1;
    do_tick(0);
    check_rd("rm_no_count", 8'd3, 32'd0);

    // Periodic on ch1 and W1C colliding with an expiry
    wr(8'd5, 32'd2);
    wr(8'd4, 32'd11);
    pulses[1] = 0;
    for (int k = 1; k <= 9; k++) begin
      do_tick(1);
      check_rd($sformatf("per_value_t%0d", k), 8'd7, 32'(2 - (k % 3)));
    end
    check_sig("per_pulses", 32'(pulses[1]), 32'd3);
    check_rd("per_status", 8'd16, 32'd2);
    check_sig("per_irq", 32'(irq), 32'd1);
    wr(8'd16, 32'd2);
    check_rd("per_w1c", 8'd16, 32'd0);
    do_tick(1);
    do_tick(1);
    tick_in[1] = 1'b1;
    step(); step();
    tick_in[1] = 1'b0;
    step();
    addr = 8'd16; wdata = 32'd2; we = 1'b1;
    step();
    we = 1'b0;
    check_rd("per_set_wins", 8'd16, 32'd2);
    check_rd("per_reload", 8'd7, 32'd2);
    wr(8'd16, 32'd2);
    wr(8'd4, 32'd0);
    step();
    check_sig("per_irq_clr", 32'(irq), 32'd0);

    // PWM on ch2 (irq_en off)
    wr(8'd9, 32'd9);
    wr(8'd10, 32'd3);
    wr(8'd8, 32'd5);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      do_tick(2);
      cnt += int'(ch_out[2]);
    end
    check_sig("pwm_high_count", 32'(cnt), 32'd3);
    check_rd("pwm_value_wrap", 8'd11, 32'd9);
    check_rd("pwm_status", 8'd16, 32'd4);
    for (int k = 0; k < 7; k++) do_tick(2);
    check_sig("pwm_high_at2", 32'(ch_out[2]), 32'd1);
    wr(8'd10, 32'd0);
    check_sig("pwm_cmp0", 32'(ch_out[2]), 32'd0);
    wr(8'd9, 32'd4);
    check_rd("pwm_load_nodisturb", 8'd11, 32'd2);
    for (int k = 0; k < 8; k++) begin
      do_tick(2);
      check_rd($sformatf("pwm_newload_t%0d", k), 8'd11, 32'(load_seq[k]));
    end
    wr(8'd8, 32'd0);
    step();
    check_sig("irq_masked", 32'(irq), 32'd0);
    wr(8'd8, 32'd8);
    step();
    check_sig("irq_unmasked", 32'(irq), 32'd1);
    wr(8'd16, 32'd4);
    step();
    check_sig("irq_cleared", 32'(irq), 32'd0);

    // Enable coinciding with a tick on ch3
    wr(8'd13, 32'd7);
    tick_in[3] = 1'b1;
    step(); step();
    tick_in[3] = 1'b0;
    step();
    addr = 8'd12; wdata = 32'd1; we = 1'b1;
    step();
    we = 1'b0;
    step();
    check_rd("en_tick_load", 8'd15, 32'd7);
    do_tick(3);
    check_rd("en_count", 8'd15, 32'd6);
    wr(8'd12, 32'd1);
    check_rd("en_rewrite", 8'd15, 32'd6);

    // Map and width
    wr(8'd13, 32'h1FF);
    check_rd("map_load_trunc", 8'd13, 32'hFF);
    check_rd("map_unmapped", 8'd17, 32'd0);
    wr(8'd15, 32'h55);
    check_rd("map_value_ro", 8'd15, 32'd6);
    check_rd("map_ctrl3", 8'd12, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
